log_mult_accum: RTL

- Accumulator stage directly downstream of the 16-bit improved logarithmic multiplier.
- Consumes the multiplier's 32-bit unsigned approximate products over a valid/ready handshake and sums a programmed number of terms into a wide accumulator.
- Presents the dot-product result on an output valid/ready handshake, with a sticky saturation flag.
- Turns the combinational multiplier into a usable approximate MAC engine.

---
 rtl/log_mult_accum_if.sv | 28 ++
 rtl/log_mult_accum.sv | 87 ++++++++
 2 files changed

// File: rtl/log_mult_accum_if.sv
// Handshake bundle between the log-multiplier accumulator and its driver/consumer.
// master drives commands and products; slave is the accumulator.
interface log_mult_accum_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );
endinterface

// File: rtl/log_mult_accum.sv
// Saturating unsigned accumulator of len multiplier products; result valid 1 cycle after last product.
// in_ready only in ACC; result held in HOLD until out_ready, start ignored outside IDLE.
module log_mult_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    log_mult_accum_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_rem;
    logic              r_ovf;
    logic              r_out_valid;

    logic [ACC_W:0]    w_sum;
    logic              w_xfer;

    // One extra bit catches the carry that signals saturation.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
    assign w_xfer = bus.in_valid && (r_state == S_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        if (bus.len != '0) begin
                            r_rem   <= bus.len;
                            r_state <= S_ACC;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (w_xfer) begin
                        if (w_sum[ACC_W]) begin
                            r_acc <= '1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == CNT_W'(1)) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_ovf   = r_ovf;
endmodule
